alu_sequencer: RTL and testbench
================================

# alu_sequencer

Sequencer in front of the 12-operation ALU. Accepts one operation request at a time over a valid/ready handshake, drives the ALU's one-hot control and operands for exactly as many cycles as the operation needs, and captures the 2×BITS result into a Z register pair (zhi/zlo). Multiply and divide get configurable multi-cycle settle windows, and illegal opcodes and divide-by-zero are flagged. Sits between the control unit and the ALU/Z-register path.

## Interface
- BITS, 32, operand width
- SIG_COUNT, 12, ALU control width (one-hot)
- MUL_WAIT, 4, cycles ALU control is held for multiply (≥1)
- DIV_WAIT, 8, cycles ALU control is held for divide (≥1)

- clock  in  1  single clock, rising edge
- clear  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_op  in  4  operation index 0–11 (0 add, 1 sub, 2 mul, 3 div, 4 shr, 5 shl, 6 ror, 7 rol, 8 and, 9 or, 10 neg, 11 not)
- req_x, req_y  in  BITS  operands
- alu_ctrl  out  SIG_COUNT  one-hot control to ALU
- alu_x, alu_y  out  BITS  operands to ALU
- alu_result  in  2×BITS  ALU output
- rsp_valid  out  1  result held
- rsp_ready  in  1  consumer takes result
- rsp_zhi, rsp_zlo  out  BITS  upper and lower halves of the captured result
- rsp_err  out  1  illegal op, or divide with req_y==0
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, EXEC, DONE.
- IDLE: req_ready=1. On req_valid&req_ready, latch op/x/y.
  - op>11: go to DONE with Z=0 and err=1. No ALU cycle.
  - Otherwise load cnt = wait(op)−1 and go to EXEC. wait(op) is MUL_WAIT for op 2, DIV_WAIT for op 3, and 1 for all others.
- EXEC:
  - alu_ctrl = 1<<op. alu_x/alu_y = latched operands.
  - cnt decrements each cycle.
  - When cnt==0: capture alu_result into {zhi,zlo}, then go to DONE.
  - Divide with y==0: the full DIV_WAIT window still runs, but Z is forced to 0 and err=1.
- DONE: rsp_valid=1, and Z/err are held stable. On rsp_ready, go to IDLE.
- Outside EXEC, alu_ctrl=0 and alu_x/alu_y=0. This gives the ALU at most one hot bit, and only during EXEC.
- Z captures all 2×BITS bits verbatim. No sign or zero extension is applied by the sequencer.
- Requests are ignored in EXEC and DONE, because req_ready=0 there.

## Timing
- Reset values (clear asserted, asynchronous): state=IDLE, cnt=0, Z=0, err=0, rsp_valid=0, busy=0, alu_ctrl=0, alu_x/alu_y=0. req_ready=0 while clear is high and 1 after release.
- Latency is measured from the accept edge k to the rsp_valid rising edge:
  - single-cycle ops: k+1
  - mul: k+MUL_WAIT
  - div: k+DIV_WAIT
  - illegal op: k+1, with no EXEC cycle
- Throughput: after a DONE handshake at edge m, req_ready is high in the cycle after m. This gives a minimum one-cycle IDLE bubble between operations.
- rsp_ready held low stalls DONE indefinitely. Outputs are held.
- clear mid-EXEC or mid-DONE aborts immediately. The in-flight result is discarded and no rsp_valid is produced.
- req_valid and rsp_ready arriving in the same cycle while in DONE: only the response completes. The request is accepted in the following IDLE cycle.

## Structure
- Package alu_seq_pkg holds:
  - opcode index constants OP_ADD…OP_NOT (0–11) and OP_LAST=11
  - state enum {IDLE, EXEC, DONE}
  - function wait_cycles(op, MUL_WAIT, DIV_WAIT)
- Sub-module alu_op_decode (combinational) maps req_op to:
  - one-hot vector
  - legal flag
  - wait count
- The top level holds the FSM, counter, operand/Z registers and handshake.

## Test plan
- add: x=5, y=7, rsp_ready=1. Expect rsp_valid at k+1, zlo=12, zhi=0, err=0. alu_ctrl=0x001 for exactly 1 cycle.
- mul with MUL_WAIT=4: x=0x0001_0000, y=0x0001_0000. Expect alu_ctrl=0x004 for 4 cycles, rsp_valid at k+4, zhi=1, zlo=0.
- div by zero with DIV_WAIT=8: x=9, y=0. Expect rsp_valid at k+8, Z=0, err=1.
- illegal op: req_op=13. Expect rsp_valid at k+1, err=1, Z=0, and alu_ctrl never nonzero.
- Backpressure: hold rsp_ready=0 for 5 cycles after a sub (x=3, y=10). Expect zlo=0xFFFF_FFF9 stable, req_ready=0 throughout, and the next request accepted only after the handshake plus one bubble.
- Reset abort: assert clear at cycle 3 of a DIV_WAIT=8 divide. Expect all outputs reset asynchronously, no rsp_valid, and req_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode indices, sequencer state encoding and per-opcode ALU hold
// length for the ALU sequencer.
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_SHR  = 4'd4;
   localparam logic [3:0] OP_SHL  = 4'd5;
   localparam logic [3:0] OP_ROR  = 4'd6;
   localparam logic [3:0] OP_ROL  = 4'd7;
   localparam logic [3:0] OP_AND  = 4'd8;
   localparam logic [3:0] OP_OR   = 4'd9;
   localparam logic [3:0] OP_NEG  = 4'd10;
   localparam logic [3:0] OP_NOT  = 4'd11;
   localparam logic [3:0] OP_LAST = 4'd11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Number of cycles the ALU control must stay asserted for an opcode.
   function automatic int unsigned wait_cycles(input logic [3:0] op,
                                               input int unsigned mul_wait,
                                               input int unsigned div_wait);
      int unsigned w;
      w = 1;
      if (op == OP_MUL) w = mul_wait;
      else if (op == OP_DIV) w = div_wait;
      return w;
   endfunction

endpackage

// File: rtl/alu_sequencer_decode.sv
// Combinational opcode decode: one-hot ALU control, legality and the number
// of cycles the control must be held.
module alu_op_decode
   import alu_seq_pkg::*;
#(
   parameter int SIG_COUNT = 12,
   parameter int MUL_WAIT  = 4,
   parameter int DIV_WAIT  = 8,
   parameter int CNT_W     = 4
) (
   input  logic [3:0]           i_op,
   output logic [SIG_COUNT-1:0] o_onehot,
   output logic                 o_legal,
   output logic [CNT_W-1:0]     o_wait
);

   always_comb begin
      o_legal  = (i_op <= OP_LAST);
      o_onehot = '0;
      if (o_legal) o_onehot[i_op] = 1'b1;
      o_wait   = CNT_W'(wait_cycles(i_op, MUL_WAIT, DIV_WAIT));
   end

endmodule

// File: rtl/alu_sequencer.sv
// Issues one ALU operation at a time: holds one-hot control and operands for
// the opcode's settle window, then captures the double-width result into Z.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int BITS      = 32,
   parameter int SIG_COUNT = 12,
   parameter int MUL_WAIT  = 4,
   parameter int DIV_WAIT  = 8
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [3:0]           req_op,
   input  logic [BITS-1:0]      req_x,
   input  logic [BITS-1:0]      req_y,
   output logic [SIG_COUNT-1:0] alu_ctrl,
   output logic [BITS-1:0]      alu_x,
   output logic [BITS-1:0]      alu_y,
   input  logic [2*BITS-1:0]    alu_result,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [BITS-1:0]      rsp_zhi,
   output logic [BITS-1:0]      rsp_zlo,
   output logic                 rsp_err,
   output logic                 busy,
   output logic [1:0]           dbg_state
);

   localparam int MAX_WAIT = (MUL_WAIT > DIV_WAIT) ? MUL_WAIT : DIV_WAIT;
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);

   state_t                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [SIG_COUNT-1:0]   r_alu_ctrl;
   logic [BITS-1:0]        r_alu_x;
   logic [BITS-1:0]        r_alu_y;
   logic [BITS-1:0]        r_zhi;
   logic [BITS-1:0]        r_zlo;
   logic                   r_err;
   logic                   r_rsp_valid;
   logic                   r_div0;

   logic [SIG_COUNT-1:0]   w_onehot;
   logic                   w_legal;
   logic [CNT_W-1:0]       w_wait;
   logic                   w_accept;

   alu_op_decode #(
      .SIG_COUNT (SIG_COUNT),
      .MUL_WAIT  (MUL_WAIT),
      .DIV_WAIT  (DIV_WAIT),
      .CNT_W     (CNT_W)
   ) u_decode (
      .i_op     (req_op),
      .o_onehot (w_onehot),
      .o_legal  (w_legal),
      .o_wait   (w_wait)
   );

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; the sender holds its payload until then, and the receiver may
   // drop ready at any time. Requests transfer only in IDLE, responses only in DONE.
   assign req_ready = (r_state == S_IDLE) && !clear;
   assign w_accept  = req_valid && req_ready;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_alu_ctrl  <= '0;
         r_alu_x     <= '0;
         r_alu_y     <= '0;
         r_zhi       <= '0;
         r_zlo       <= '0;
         r_err       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_div0      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (!w_legal) begin
                     r_zhi       <= '0;
                     r_zlo       <= '0;
                     r_err       <= 1'b1;
                     r_rsp_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_cnt      <= w_wait - CNT_W'(1);
                     r_alu_ctrl <= w_onehot;
                     r_alu_x    <= req_x;
                     r_alu_y    <= req_y;
                     r_div0     <= (req_op == OP_DIV) && (req_y == '0);
                     r_state    <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               if (r_cnt == '0) begin
                  // Divide-by-zero still occupies the full window; only Z is suppressed.
                  {r_zhi, r_zlo} <= r_div0 ? '0 : alu_result;
                  r_err          <= r_div0;
                  r_alu_ctrl     <= '0;
                  r_alu_x        <= '0;
                  r_alu_y        <= '0;
                  r_rsp_valid    <= 1'b1;
                  r_state        <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign alu_ctrl  = r_alu_ctrl;
   assign alu_x     = r_alu_x;
   assign alu_y     = r_alu_y;
   assign rsp_valid = r_rsp_valid;
   assign rsp_zhi   = r_zhi;
   assign rsp_zlo   = r_zlo;
   assign rsp_err   = r_err;
   assign busy      = (r_state != S_IDLE);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: plays the ALU, drives directed and random requests,
// and checks response value, latency and control-hold length against a model.
module tb_alu_sequencer;

   localparam int BITS      = 32;
   localparam int SIG_COUNT = 12;
   localparam int MUL_WAIT  = 4;
   localparam int DIV_WAIT  = 8;

   logic                 clock = 1'b0;
   logic                 clear = 1'b1;
   logic                 req_valid = 1'b0;
   logic                 req_ready;
   logic [3:0]           req_op = '0;
   logic [BITS-1:0]      req_x = '0;
   logic [BITS-1:0]      req_y = '0;
   logic [SIG_COUNT-1:0] alu_ctrl;
   logic [BITS-1:0]      alu_x;
   logic [BITS-1:0]      alu_y;
   logic [2*BITS-1:0]    alu_result;
   logic                 rsp_valid;
   logic                 rsp_ready = 1'b0;
   logic [BITS-1:0]      rsp_zhi;
   logic [BITS-1:0]      rsp_zlo;
   logic                 rsp_err;
   logic                 busy;
   logic [1:0]           dbg_state;

   int total = 0;
   int bad   = 0;
   logic [64:0] exp_q[$];

   alu_sequencer #(
      .BITS(BITS), .SIG_COUNT(SIG_COUNT), .MUL_WAIT(MUL_WAIT), .DIV_WAIT(DIV_WAIT)
   ) dut (
      .clock(clock), .clear(clear),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_x(req_x), .req_y(req_y),
      .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_zhi(rsp_zhi), .rsp_zlo(rsp_zlo), .rsp_err(rsp_err),
      .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clock = ~clock;

   // Behavioural ALU: what the real ALU would produce for a given operation.
   function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                           input logic [31:0] y);
      logic [63:0] xx;
      logic [4:0]  sh;
      xx = {x, x};
      sh = y[4:0];
      case (op)
         4'd0:    return {32'd0, x + y};
         4'd1:    return {32'd0, x - y};
         4'd2:    return {32'd0, x} * {32'd0, y};
         4'd3:    return (y == 0) ? 64'hDEAD_BEEF_0BAD_F00D : {x % y, x / y};
         4'd4:    return {32'd0, x >> sh};
         4'd5:    return {32'd0, x << sh};
         4'd6:    return {32'd0, 32'(xx >> sh)};
         4'd7:    return {32'd0, 32'((xx << sh) >> 32)};
         4'd8:    return {32'd0, x & y};
         4'd9:    return {32'd0, x | y};
         4'd10:   return {32'd0, -x};
         4'd11:   return {32'd0, ~x};
         default: return 64'hA5A5_A5A5_5A5A_5A5A;
      endcase
   endfunction

   always_comb begin
      logic [3:0] idx;
      logic       hit;
      idx = '0;
      hit = 1'b0;
      for (int i = 0; i < SIG_COUNT; i++) begin
         if (alu_ctrl[i]) begin
            idx = 4'(i);
            hit = 1'b1;
         end
      end
      alu_result = hit ? ref_alu(idx, alu_x, alu_y) : 64'hA5A5_A5A5_5A5A_5A5A;
   end

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input int stall);
      int          guard;
      int          lat;
      int          hot;
      int          exp_lat;
      logic        exp_err;
      logic [11:0] exp_hot;
      logic [64:0] exp_rsp;
      logic [64:0] got;
      guard = 0;
      while (!req_ready && guard < 20) begin
         step();
         guard++;
      end
      chk("ready_before_req", 72'(req_ready), 72'(1'b1));
      req_op = op; req_x = x; req_y = y; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      exp_err = (op > 4'd11) || (op == 4'd3 && y == 0);
      exp_q.push_back({exp_err, exp_err ? 64'd0 : ref_alu(op, x, y)});
      exp_lat = (op > 4'd11) ? 0 : (op == 4'd2) ? MUL_WAIT : (op == 4'd3) ? DIV_WAIT : 1;
      exp_hot = '0;
      if (op <= 4'd11) exp_hot[op] = 1'b1;
      lat = 0;
      hot = 0;
      while (!rsp_valid && lat < 40) begin
         if (alu_ctrl != '0) begin
            hot++;
            chk("alu_ctrl", 72'(alu_ctrl), 72'(exp_hot));
            chk("alu_xy", 72'({alu_x, alu_y}), 72'({x, y}));
         end
         step();
         lat++;
      end
      chk("latency", 72'(lat), 72'(exp_lat));
      chk("ctrl_cycles", 72'(hot), 72'(exp_lat));
      exp_rsp = exp_q.pop_front();
      got = {rsp_err, rsp_zhi, rsp_zlo};
      chk("rsp", 72'(got), 72'(exp_rsp));
      chk("ctrl_idle_done", 72'(alu_ctrl), 72'(0));
      for (int s = 0; s < stall; s++) begin
         req_valid = 1'b1;
         req_op = 4'($urandom_range(0, 11));
         step();
         chk("stall_valid", 72'(rsp_valid), 72'(1'b1));
         chk("stall_hold", 72'({rsp_err, rsp_zhi, rsp_zlo}), 72'(exp_rsp));
         chk("stall_ready", 72'(req_ready), 72'(1'b0));
      end
      rsp_ready = 1'b1;
      req_valid = (stall > 0);
      step();
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      chk("post_hs_valid", 72'(rsp_valid), 72'(1'b0));
      chk("post_hs_idle", 72'({busy, req_ready}), 72'(2'b01));
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      #1;
      chk("reset_ready", 72'(req_ready), 72'(1'b0));
      chk("reset_rsp", 72'({rsp_valid, rsp_err, rsp_zhi, rsp_zlo}), 72'(0));
      chk("reset_alu", 72'({alu_ctrl, alu_x, alu_y}), 72'(0));
      chk("reset_busy", 72'({busy, dbg_state}), 72'(0));
      step();
      step();
      clear = 1'b0;
      #1;
      chk("release_ready", 72'(req_ready), 72'(1'b1));

      run_op(4'd0, 32'd5, 32'd7, 0);
      chk("add_zlo", 72'(rsp_zlo), 72'(12));
      run_op(4'd2, 32'h0001_0000, 32'h0001_0000, 0);
      chk("mul_z", 72'({rsp_zhi, rsp_zlo}), 72'(64'h1_0000_0000));
      run_op(4'd3, 32'd9, 32'd0, 0);
      chk("div0_err", 72'(rsp_err), 72'(1'b1));
      run_op(4'd13, 32'd1, 32'd2, 0);
      run_op(4'd1, 32'd3, 32'd10, 5);
      chk("sub_zlo", 72'(rsp_zlo), 72'(32'hFFFF_FFF9));
      run_op(4'd3, 32'd100, 32'd7, 1);

      for (int n = 0; n < 24; n++) begin
         op = 4'($urandom_range(0, 13));
         x  = $urandom;
         y  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         run_op(op, x, y, $urandom_range(0, 3));
      end

      req_op = 4'd3; req_x = 32'd9; req_y = 32'd3; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      step();
      clear = 1'b1;
      #1;
      chk("abort_rsp", 72'({rsp_valid, rsp_err, rsp_zhi, rsp_zlo}), 72'(0));
      chk("abort_alu", 72'({alu_ctrl, alu_x, alu_y}), 72'(0));
      chk("abort_busy_ready", 72'({busy, req_ready}), 72'(0));
      step();
      clear = 1'b0;
      #1;
      chk("abort_release_ready", 72'(req_ready), 72'(1'b1));
      for (int c = 0; c < DIV_WAIT + 2; c++) begin
         step();
         chk("abort_no_rsp", 72'({rsp_valid, busy}), 72'(0));
      end
      run_op(4'd7, 32'h8000_0001, 32'd4, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
